st7789_spi_arbiter: RTL and testbench

Shares the single ST7789 SPI byte sender between two requesters: a command port (CPU/MMIO side, high priority) and a pixel stream port (frame streamer issuing RAMWR data). Transactions are grant-locked so DC/command/parameter sequences never interleave. The pixel stream is preemptible at byte boundaries after a minimum slice; on regrant the arbiter injects a RAMWRC (0x3C) command so the panel continues writing at the interrupted address. It sits between the requesters and the byte-level SPI sender, driving that sender's `en`, `d_in[8:0]` and `busy` interface.

---
 rtl/st7789_spi_arbiter.sv | 88 ++++++++
 tb/tb_st7789_spi_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/st7789_spi_arbiter.sv
// st7789_spi_arbiter: shares one ST7789 SPI byte sender between a command port and a pixel stream port
// Ports:
//   w_clk, w_rst_n          clock, synchronous active-low reset
//   r0_valid/data/last      command port (high priority, never preempted); r0_ready accepts a byte
//   r1_valid/data/last      pixel stream port (preemptible after MIN_SLICE bytes); r1_ready accepts a byte
//   o_en, o_data            one-cycle start pulse and {DC,byte} to the SPI sender
//   i_busy                  SPI sender busy (high from the o_en cycle through the shift)
//   o_gnt                   current owner {r1,r0}, 00 when idle or injecting RAMWRC
//   o_resume_pending        stream was preempted; next stream grant is preceded by RAMWRC (0x3C)
module st7789_spi_arbiter #(
  parameter int MIN_SLICE = 480
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       r0_valid,
  input  logic [8:0] r0_data,
  input  logic       r0_last,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [8:0] r1_data,
  input  logic       r1_last,
  output logic       r1_ready,
  output logic       o_en,
  output logic [8:0] o_data,
  input  logic       i_busy,
  output logic [1:0] o_gnt,
  output logic       o_resume_pending
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam logic [1:0] INJ  = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        en_q, en_d;
  logic [8:0]  data_q, data_d;
  logic        resume_q, resume_d;
  logic [15:0] slice_q, slice_d;
  logic        slot, preempt, xfer0, xfer1, inj;
  always_comb begin
    slot     = !i_busy && !en_q;
    // preemption wins the slot, so the stream byte is held back rather than sent
    preempt  = (state_q == GNT1) && slot && r0_valid && (slice_q >= 16'(MIN_SLICE));
    r0_ready = w_rst_n && (state_q == GNT0) && slot;
    r1_ready = w_rst_n && (state_q == GNT1) && slot && !preempt;
    xfer0    = r0_valid && r0_ready;
    xfer1    = r1_valid && r1_ready;
    inj      = w_rst_n && (state_q == INJ) && slot;
    state_d  = state_q;
    resume_d = resume_q;
    if (state_q == IDLE && slot)
      state_d = r0_valid ? GNT0 : r1_valid ? (resume_q ? INJ : GNT1) : IDLE;
    if (xfer0 && r0_last)
      state_d = IDLE;
    if (xfer1 && r1_last) begin
      state_d  = IDLE;
      resume_d = 1'b0;
    end
    if (preempt) begin
      state_d  = IDLE;
      resume_d = 1'b1;
    end
    if (inj)
      state_d = GNT1;
    // held at zero outside GNT1 so every stream grant starts a fresh slice
    slice_d = (state_q != GNT1) ? 16'd0 : (xfer1 && slice_q != 16'hFFFF) ? slice_q + 16'd1 : slice_q;
    en_d    = xfer0 || xfer1 || inj;
    data_d  = xfer0 ? r0_data : xfer1 ? r1_data : inj ? 9'h03C : data_q;
  end
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      data_q   <= 9'h000;
      resume_q <= 1'b0;
      slice_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      data_q   <= data_d;
      resume_q <= resume_d;
      slice_q  <= slice_d;
    end
  end
  assign o_en             = en_q;
  assign o_data           = data_q;
  assign o_gnt            = {state_q == GNT1, state_q == GNT0};
  assign o_resume_pending = resume_q;
endmodule

// File: tb/tb_st7789_spi_arbiter.sv
// tb_st7789_spi_arbiter: directed scenarios for the ST7789 SPI arbiter with a 19-cycle byte sender model
module tb_st7789_spi_arbiter;
  logic       w_clk = 1'b0;
  logic       w_rst_n = 1'b0;
  logic       r0_valid = 1'b0, r0_last = 1'b0, r1_valid = 1'b0, r1_last = 1'b0;
  logic [8:0] r0_data = 9'h0, r1_data = 9'h0;
  logic       r0_ready, r1_ready, o_en, o_resume_pending, i_busy;
  logic [8:0] o_data;
  logic [1:0] o_gnt;
  int         checks = 0, errors = 0;
  int         busy_cnt = 0;
  int         busy_len = 19;
  logic [9:0] q0[$], q1[$];
  logic [8:0] log_q[$];
  bit         rp_seen = 0;
  logic       f0, f1;

  st7789_spi_arbiter #(.MIN_SLICE(4)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_ready(r1_ready),
    .o_en(o_en), .o_data(o_data), .i_busy(i_busy), .o_gnt(o_gnt),
    .o_resume_pending(o_resume_pending)
  );

  always #5 w_clk = ~w_clk;

  assign i_busy = o_en | (busy_cnt != 0);
  always @(posedge w_clk) busy_cnt <= o_en ? busy_len - 1 : (busy_cnt != 0 ? busy_cnt - 1 : 0);

  always @(negedge w_clk) begin
    if (o_en) log_q.push_back(o_data);
    if (o_resume_pending) rp_seen = 1;
  end

  initial forever begin
    @(negedge w_clk);
    f0 = r0_valid && r0_ready;
    f1 = r1_valid && r1_ready;
    @(posedge w_clk);
    #1;
    if (f0 && q0.size() != 0) void'(q0.pop_front());
    if (f1 && q1.size() != 0) void'(q1.pop_front());
    r0_valid = q0.size() != 0;
    {r0_last, r0_data} = q0.size() != 0 ? q0[0] : 10'h0;
    r1_valid = q1.size() != 0;
    {r1_last, r1_data} = q1.size() != 0 ? q1[0] : 10'h0;
  end

  task automatic wait_log(input int n, output bit ok);
    for (int i = 0; i < 3000 && log_q.size() < n; i++) @(negedge w_clk);
    ok = log_q.size() >= n;
  endtask

  task automatic settle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge w_clk);
      if (q0.size() == 0 && q1.size() == 0 && !r0_valid && !r1_valid && o_gnt == 2'b00 && busy_cnt == 0 && !o_en) break;
    end
    repeat (3) @(negedge w_clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge w_clk);
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", r1_ready, r0_ready); end
    w_rst_n = 1'b1;
    @(negedge w_clk);
    checks++; if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_en); end
    checks++; if (o_data !== 9'h000) begin errors++; $display("FAIL reset_data got %h want 000", o_data); end
    checks++; if (o_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", o_gnt); end
    checks++; if (o_resume_pending !== 1'b0) begin errors++; $display("FAIL reset_resume got %b want 0", o_resume_pending); end
  endtask

  task automatic test_lone_stream();
    logic [8:0] exp [7];
    bit ok;
    exp = '{9'h02C, 9'h112, 9'h134, 9'h156, 9'h178, 9'h19A, 9'h1BC};
    log_q.delete(); rp_seen = 0;
    foreach (exp[i]) q1.push_back({i == 6, exp[i]});
    wait_log(7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lone_timeout got %0d want 7", log_q.size()); end
    settle();
    checks++; if (log_q.size() != 7) begin errors++; $display("FAIL lone_count got %0d want 7", log_q.size()); end
    foreach (exp[i]) begin
      checks++;
      if ((i < log_q.size() ? log_q[i] : 9'hx) !== exp[i]) begin errors++; $display("FAIL lone_byte%0d got %h want %h", i, i < log_q.size() ? log_q[i] : 9'hx, exp[i]); end
    end
    checks++; if (rp_seen) begin errors++; $display("FAIL lone_resume got 1 want 0"); end
  endtask

  task automatic test_command_during_stream();
    logic [8:0] exp [10];
    bit ok;
    exp = '{9'h02C, 9'h101, 9'h102, 9'h103, 9'h02A, 9'h100, 9'h1EF, 9'h03C, 9'h104, 9'h105};
    log_q.delete();
    for (int i = 0; i < 6; i++) q1.push_back({i == 5, i == 0 ? 9'h02C : 9'h100 + 9'(i)});
    wait_log(2, ok);
    q0.push_back({1'b0, 9'h02A}); q0.push_back({1'b0, 9'h100}); q0.push_back({1'b1, 9'h1EF});
    wait_log(5, ok);
    checks++; if (o_resume_pending !== 1'b1) begin errors++; $display("FAIL pre_resume_cmd got %b want 1", o_resume_pending); end
    checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL pre_gnt_cmd got %b want 01", o_gnt); end
    wait_log(8, ok);
    checks++; if (o_resume_pending !== 1'b1) begin errors++; $display("FAIL pre_resume_inj got %b want 1", o_resume_pending); end
    wait_log(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pre_timeout got %0d want 10", log_q.size()); end
    checks++; if (o_resume_pending !== 1'b0) begin errors++; $display("FAIL pre_resume_last got %b want 0", o_resume_pending); end
    settle();
    checks++; if (log_q.size() != 10) begin errors++; $display("FAIL pre_count got %0d want 10", log_q.size()); end
    foreach (exp[i]) begin
      checks++;
      if ((i < log_q.size() ? log_q[i] : 9'hx) !== exp[i]) begin errors++; $display("FAIL pre_byte%0d got %h want %h", i, i < log_q.size() ? log_q[i] : 9'hx, exp[i]); end
    end
  endtask

  task automatic test_no_preempt();
    logic [8:0] exp [5];
    bit ok, bad_gnt, bad_r1;
    exp = '{9'h02B, 9'h100, 9'h110, 9'h02C, 9'h1AA};
    log_q.delete(); bad_gnt = 0; bad_r1 = 0;
    q0.push_back({1'b0, 9'h02B});
    wait_log(1, ok);
    q1.push_back({1'b0, 9'h02C}); q1.push_back({1'b1, 9'h1AA});
    repeat (40) begin
      @(negedge w_clk);
      if (o_gnt !== 2'b01) bad_gnt = 1;
      if (r1_ready) bad_r1 = 1;
    end
    checks++; if (bad_gnt) begin errors++; $display("FAIL nopre_gnt got %b want 01", o_gnt); end
    checks++; if (bad_r1 || log_q.size() != 1) begin errors++; $display("FAIL nopre_r1 got %0d bytes want 1", log_q.size()); end
    q0.push_back({1'b0, 9'h100}); q0.push_back({1'b1, 9'h110});
    wait_log(5, ok);
    settle();
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL nopre_count got %0d want 5", log_q.size()); end
    foreach (exp[i]) begin
      checks++;
      if ((i < log_q.size() ? log_q[i] : 9'hx) !== exp[i]) begin errors++; $display("FAIL nopre_byte%0d got %h want %h", i, i < log_q.size() ? log_q[i] : 9'hx, exp[i]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp [4];
    bit ok;
    exp = '{9'h036, 9'h100, 9'h02C, 9'h155};
    log_q.delete(); rp_seen = 0;
    q0.push_back({1'b0, 9'h036}); q0.push_back({1'b1, 9'h100});
    q1.push_back({1'b0, 9'h02C}); q1.push_back({1'b1, 9'h155});
    wait_log(4, ok);
    settle();
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL simul_count got %0d want 4", log_q.size()); end
    foreach (exp[i]) begin
      checks++;
      if ((i < log_q.size() ? log_q[i] : 9'hx) !== exp[i]) begin errors++; $display("FAIL simul_byte%0d got %h want %h", i, i < log_q.size() ? log_q[i] : 9'hx, exp[i]); end
    end
    checks++; if (rp_seen) begin errors++; $display("FAIL simul_resume got 1 want 0"); end
  endtask

  task automatic test_reset_mid_stream();
    bit ok, bad_en;
    log_q.delete();
    for (int i = 0; i < 7; i++) q1.push_back({i == 6, i == 0 ? 9'h02C : 9'h1A0 + 9'(i)});
    wait_log(2, ok);
    q0.push_back({1'b1, 9'h029});
    wait_log(7, ok);
    checks++; if (!ok || log_q[5] !== 9'h03C || o_resume_pending !== 1'b1) begin errors++; $display("FAIL rst_setup got %0d bytes resume %b want 7 bytes resume 1", log_q.size(), o_resume_pending); end
    q1.delete();
    w_rst_n = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    checks++; if (i_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", i_busy); end
    checks++; if (o_en !== 1'b0 || o_data !== 9'h000) begin errors++; $display("FAIL rst_out got en %b data %h want en 0 data 000", o_en, o_data); end
    checks++; if (o_gnt !== 2'b00 || o_resume_pending !== 1'b0) begin errors++; $display("FAIL rst_state got gnt %b resume %b want 00 0", o_gnt, o_resume_pending); end
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b want 00", r1_ready, r0_ready); end
    log_q.delete(); bad_en = 0;
    q1.push_back({1'b0, 9'h02C}); q1.push_back({1'b1, 9'h177});
    for (int i = 0; i < 3000 && log_q.size() < 2; i++) begin
      @(negedge w_clk);
      if (o_en && busy_cnt != 0) bad_en = 1;
    end
    checks++; if (bad_en) begin errors++; $display("FAIL rst_en_busy got 1 want 0"); end
    settle();
    checks++; if (log_q.size() != 2 || log_q[0] !== 9'h02C || log_q[1] !== 9'h177) begin errors++; $display("FAIL rst_resume_stream got %0d bytes first %h want 2 bytes 02c 177", log_q.size(), log_q.size() ? log_q[0] : 9'hx); end
  endtask

  task automatic test_pacing();
    bit ok, bad_rdy, bad_wide, bad_gap, prev_en;
    int last_cyc, cyc;
    log_q.delete(); bad_rdy = 0; bad_wide = 0; bad_gap = 0; prev_en = 0; last_cyc = -1; cyc = 0;
    for (int i = 0; i < 6; i++) q1.push_back({i == 5, i == 0 ? 9'h02C : 9'h1C0 + 9'(i)});
    for (int i = 0; i < 3000 && log_q.size() < 6; i++) begin
      @(negedge w_clk);
      cyc++;
      if ((r0_ready || r1_ready) && (i_busy || o_en)) bad_rdy = 1;
      if (o_en && prev_en) bad_wide = 1;
      if (o_en) begin
        if (last_cyc >= 0 && cyc - last_cyc != 20) bad_gap = 1;
        last_cyc = cyc;
      end
      prev_en = o_en;
    end
    ok = log_q.size() == 6;
    checks++; if (!ok) begin errors++; $display("FAIL pace_count got %0d want 6", log_q.size()); end
    checks++; if (bad_rdy) begin errors++; $display("FAIL pace_ready got 1 want 0"); end
    checks++; if (bad_wide) begin errors++; $display("FAIL pace_en_width got 2+ want 1"); end
    checks++; if (bad_gap) begin errors++; $display("FAIL pace_gap got not 20 want 20"); end
    settle();
  endtask

  initial begin
    test_reset();
    test_lone_stream();
    test_command_during_stream();
    test_no_preempt();
    test_simultaneous();
    test_reset_mid_stream();
    test_pacing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
